// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
//   Multi-cycle WIDTH-bit adder/subtractor. Each operation is processed
//   DIGIT bits per clock through one registered ripple-carry digit slice, so
//   an operation takes NDIG = WIDTH/DIGIT digit cycles. Requests use a
//   start/busy/done handshake.
//
//   Subtraction is computed as a + ~b + ~cin, which equals a - b - cin modulo
//   2^WIDTH. In that mode cout reads as "no borrow".
//
// Parameters
//   WIDTH    operand/result width, must be a multiple of DIGIT
//   DIGIT    bits processed per clock, 1..WIDTH
//
// Ports
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset; aborts any operation in flight
//   start     request, sampled when not busy (IDLE or DONE)
//   sub       0: a+b+cin, 1: a-b-cin (sampled with start)
//   a, b      operands (sampled with start)
//   cin       carry-in / borrow-in (sampled with start)
//   busy      high while digits are being processed
//   done      one-cycle pulse, result outputs just updated
//   sum       result, held until the next completion
//   cout      carry out of the MSB (sub: 1 = no borrow)
//   overflow  two's-complement signed overflow of the operation
// ---------------------------------------------------------------------------
module serial_addsub #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

   generate
      if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
         $error("serial_addsub: WIDTH must be a positive multiple of DIGIT");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // Operand shift registers: the current digit always sits in the low bits.
   logic [WIDTH-1:0] r_opa;
   logic [WIDTH-1:0] r_opb;
   // Result shift register: digits enter at the top and move down, so after
   // NDIG shifts digit 0 lands in the least significant position.
   logic [WIDTH-1:0] r_res;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   // Sign bits of A and B' kept aside, since the operand registers are
   // shifted away by the time the overflow flag is computed.
   logic             r_a_msb;
   logic             r_b_msb;

   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;

   logic [WIDTH-1:0]       w_bsel;
   logic [DIGIT-1:0]       w_da;
   logic [DIGIT-1:0]       w_db;
   logic [DIGIT-1:0]       w_dsum;
   logic                   w_dcarry;
   logic [WIDTH+DIGIT-1:0] w_res_cat;
   logic [WIDTH+DIGIT-1:0] w_opa_cat;
   logic [WIDTH+DIGIT-1:0] w_opb_cat;
   logic [WIDTH-1:0]       w_res_nxt;
   logic                   w_last;
   logic                   w_accept;

   // Subtraction folds into addition: invert B and the incoming borrow.
   assign w_bsel   = sub ? ~b : b;
   assign w_accept = start && (r_state != S_RUN);
   assign w_last   = (r_cnt == LAST_CNT);

   // Digit slice: DIGIT-bit ripple add with carry in from the previous digit.
   assign w_da = r_opa[DIGIT-1:0];
   assign w_db = r_opb[DIGIT-1:0];
   assign {w_dcarry, w_dsum} = {1'b0, w_da} + {1'b0, w_db} + {{DIGIT{1'b0}}, r_carry};

   // Shifts are done on zero-extended concatenations so that DIGIT == WIDTH
   // (a single-digit operation) needs no special case.
   assign w_res_cat = {w_dsum, r_res} >> DIGIT;
   assign w_opa_cat = {{DIGIT{1'b0}}, r_opa} >> DIGIT;
   assign w_opb_cat = {{DIGIT{1'b0}}, r_opb} >> DIGIT;
   assign w_res_nxt = w_res_cat[WIDTH-1:0];

   // ------------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_RUN;
         S_RUN:   if (w_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_opa   <= '0;
         r_opb   <= '0;
         r_res   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_a_msb <= 1'b0;
         r_b_msb <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_accept) begin
         r_opa   <= a;
         r_opb   <= w_bsel;
         r_carry <= cin ^ sub;
         r_cnt   <= '0;
         r_a_msb <= a[WIDTH-1];
         r_b_msb <= w_bsel[WIDTH-1];
      end else if (r_state == S_RUN) begin
         r_opa   <= w_opa_cat[WIDTH-1:0];
         r_opb   <= w_opb_cat[WIDTH-1:0];
         r_res   <= w_res_nxt;
         r_carry <= w_dcarry;
         r_cnt   <= r_cnt + 1'b1;
         // Visible outputs only move on the final digit, never mid-operation.
         if (w_last) begin
            r_sum  <= w_res_nxt;
            r_cout <= w_dcarry;
            r_ovf  <= (r_a_msb == r_b_msb) && (w_res_nxt[WIDTH-1] != r_a_msb);
         end
      end
   end

   assign busy     = (r_state == S_RUN);
   assign done     = (r_state == S_DONE);
   assign sum      = r_sum;
   assign cout     = r_cout;
   assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub
//   Directed bench for serial_addsub: a WIDTH=16/DIGIT=4 instance for the
//   hand-computed vectors, handshake and reset cases, and three WIDTH=4
//   instances (DIGIT 1, 2, 4) swept over every a, b, cin, sub combination
//   against an integer arithmetic model.
// ---------------------------------------------------------------------------
module tb_serial_addsub;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // 16-bit, 4-bit digit instance
   logic        m_start = 1'b0, m_sub = 1'b0, m_cin = 1'b0;
   logic [15:0] m_a = '0, m_b = '0;
   logic        m_busy, m_done, m_cout, m_ovf;
   logic [15:0] m_sum;

   serial_addsub #(.WIDTH(16), .DIGIT(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(m_start), .sub(m_sub),
      .a(m_a), .b(m_b), .cin(m_cin),
      .busy(m_busy), .done(m_done), .sum(m_sum), .cout(m_cout), .overflow(m_ovf)
   );

   // 4-bit instances, DIGIT = 1, 2, 4 (NDIG = 4, 2, 1)
   logic            s_start = 1'b0, s_sub = 1'b0, s_cin = 1'b0;
   logic [3:0]      s_a = '0, s_b = '0;
   logic [2:0]      s_busy, s_done, s_cout, s_ovf;
   logic [2:0][3:0] s_sum;

   for (genvar g = 0; g < 3; g++) begin : g_sw
      serial_addsub #(.WIDTH(4), .DIGIT(1 << g)) u_sw (
         .clk(clk), .rst_n(rst_n), .start(s_start), .sub(s_sub),
         .a(s_a), .b(s_b), .cin(s_cin),
         .busy(s_busy[g]), .done(s_done[g]), .sum(s_sum[g]),
         .cout(s_cout[g]), .overflow(s_ovf[g])
      );
   end

   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] prev_sum = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Launch one 16-bit operation and follow it cycle by cycle to done.
   // With noise set, stray start pulses with different operands are
   // driven while the operation is running.
   task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub,
                        input logic [15:0] es, input logic ec, input logic eo,
                        input bit noise);
      m_start = 1'b1; m_a = a; m_b = b; m_cin = cin; m_sub = sub;
      step();
      for (int c = 0; c <= 4; c++) begin
         chk({tag, " busy"}, m_busy, (c < 4));
         chk({tag, " done"}, m_done, (c == 4));
         if (c < 4) chk({tag, " sum held"}, m_sum, prev_sum);
         if (noise && c < 3) begin
            m_start = 1'b1; m_a = 16'hFFFF; m_b = 16'hFFFF; m_cin = 1'b1; m_sub = ~sub;
         end else begin
            m_start = 1'b0;
         end
         if (c < 4) step();
      end
      chk({tag, " sum"}, m_sum, es);
      chk({tag, " cout"}, m_cout, ec);
      chk({tag, " ovf"}, m_ovf, eo);
      prev_sum = es;
   endtask

   // Watchdog: the sequence below is fixed length, this only guards a hang.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int         ia, ib, ic, sa, sb, r, sr;
   logic [3:0] es4;
   logic       ec4, eo4;

   initial begin
      // ---------------- reset held with start asserted ----------------
      rst_n = 1'b0;
      m_start = 1'b1; m_a = 16'($urandom); m_b = 16'($urandom); m_sub = 1'b0;
      s_start = 1'b1; s_a = 4'($urandom); s_b = 4'($urandom);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst busy", m_busy, 1'b0);
         chk("rst done", m_done, 1'b0);
         chk("rst sum", m_sum, 16'h0000);
         chk("rst cout", m_cout, 1'b0);
         chk("rst ovf", m_ovf, 1'b0);
         chk("rst sw busy", s_busy, 3'b000);
         chk("rst sw done", s_done, 3'b000);
      end
      m_start = 1'b0; s_start = 1'b0;
      rst_n = 1'b1;
      step();
      chk("post-rst busy", m_busy, 1'b0);
      chk("post-rst done", m_done, 1'b0);

      // ---------------- additions ----------------
      run16("add1", 16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0);
      step();  // back to IDLE between operations
      chk("idle after done", m_done, 1'b0);
      run16("add2", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      run16("add3", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
      run16("add4", 16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1, 1'b0);

      // ---------------- subtractions ----------------
      run16("sub1", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
      run16("sub2", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
      run16("sub3", 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0, 1'b0);

      // ---------------- handshake: start ignored in RUN ----------------
      run16("hs1", 16'h0100, 16'h0023, 1'b0, 1'b0, 16'h0123, 1'b0, 1'b0, 1'b1);
      // accepted directly from DONE, sum holds 0x0123 until its done
      run16("hs2", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);
      run16("hs3", 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0, 1'b0);

      // ---------------- reset mid-RUN ----------------
      m_start = 1'b1; m_a = 16'h1111; m_b = 16'h2222; m_cin = 1'b0; m_sub = 1'b0;
      step();
      m_start = 1'b0;
      step();
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("midrst busy", m_busy, 1'b0);
      chk("midrst done", m_done, 1'b0);
      chk("midrst sum", m_sum, 16'h0000);
      chk("midrst cout", m_cout, 1'b0);
      step();
      chk("midrst held busy", m_busy, 1'b0);
      rst_n = 1'b1;
      step();
      chk("midrst idle", m_busy, 1'b0);
      prev_sum = 16'h0000;
      run16("after rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
      step();

      // ---------------- WIDTH=4 sweep, DIGIT 1/2/4 ----------------
      for (int op = 0; op < 1024; op++) begin
         s_b   = 4'(op & 15);
         s_a   = 4'((op >> 4) & 15);
         s_cin = 1'((op >> 8) & 1);
         s_sub = 1'((op >> 9) & 1);
         ia = int'(s_a); ib = int'(s_b); ic = int'(s_cin);
         sa = (ia >= 8) ? ia - 16 : ia;
         sb = (ib >= 8) ? ib - 16 : ib;
         if (s_sub) begin
            r   = ia - ib - ic;
            ec4 = (r >= 0);
            sr  = sa - sb - ic;
         end else begin
            r   = ia + ib + ic;
            ec4 = (r >= 16);
            sr  = sa + sb + ic;
         end
         es4 = 4'(r & 15);
         eo4 = (sr > 7) || (sr < -8);

         s_start = 1'b1;
         step();
         s_start = 1'b0;
         for (int c = 1; c <= 4; c++) begin
            step();
            for (int g = 0; g < 3; g++) begin
               chk($sformatf("sw d%0d op%0d c%0d done", 1 << g, op, c), s_done[g], (c == (4 >> g)));
               if (c == (4 >> g)) begin
                  chk($sformatf("sw d%0d op%0d sum", 1 << g, op), s_sum[g], es4);
                  chk($sformatf("sw d%0d op%0d cout", 1 << g, op), s_cout[g], ec4);
                  chk($sformatf("sw d%0d op%0d ovf", 1 << g, op), s_ovf[g], eo4);
               end
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
